demux_stream: RTL and testbench

DEMUX_STREAM -- requirements
Module: demux_stream

---
 rtl/demux_stream_pkg.sv | 16 +
 rtl/demux_slot.sv | 61 ++++++
 rtl/demux_stream.sv | 113 +++++++++++
 tb/tb_demux_stream.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/demux_stream_pkg.sv
// -----------------------------------------------------------------------------
// demux_stream_pkg
// Shared constants for the 1-to-2 stream demultiplexer:
//   DEFAULT_WIDTH  - default data width of the input and both output ports
//   DEFAULT_CNT_W  - default width of each per-port transfer counter
//   SEL_A / SEL_B  - in_sel encodings that route a word to port A or port B
// -----------------------------------------------------------------------------
package demux_stream_pkg;

   localparam int   DEFAULT_WIDTH = 2;
   localparam int   DEFAULT_CNT_W = 8;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

endpackage : demux_stream_pkg

// File: rtl/demux_slot.sv
// -----------------------------------------------------------------------------
// demux_slot
// One output holding register: a single data word plus a full flag.
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset; empties the slot, clears data
//   load       - write load_data this cycle (caller guarantees room)
//   load_data  - word to store
//   out_ready  - downstream consumer accepts the held word
//   full       - slot holds a word (drives the port valid)
//   data       - held word; keeps its last value after draining
// -----------------------------------------------------------------------------
module demux_slot
   import demux_stream_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             out_ready,
   output logic             full,
   output logic [WIDTH-1:0] data
);

   logic             full_r;
   logic [WIDTH-1:0] data_r;
   logic             drain_s;

   // Drain happens only when a word is actually present and taken.
   always_comb begin
      drain_s = 1'b0;
      if (full_r) begin
         drain_s = out_ready;
      end else begin
         drain_s = 1'b0;
      end
   end

   // Holding register: a load wins over a drain so a simultaneous
   // drain+load leaves the slot full with the new word.
   always_ff @(posedge clk) begin
      if (rst) begin
         full_r <= 1'b0;
         data_r <= {WIDTH{1'b0}};
      end else if (load) begin
         full_r <= 1'b1;
         data_r <= load_data;
      end else if (drain_s) begin
         full_r <= 1'b0;
         data_r <= data_r;
      end else begin
         full_r <= full_r;
         data_r <= data_r;
      end
   end

   assign full = full_r;
   assign data = data_r;

endmodule : demux_slot

// File: rtl/demux_stream.sv
// -----------------------------------------------------------------------------
// demux_stream
// Routes a valid/ready input stream to one of two output streams (A or B)
// chosen per word by in_sel, with one holding register per output and a
// per-port count of accepted words.
//   clk, rst            - clock and synchronous active-high reset
//   in_valid/in_ready   - input handshake
//   in_data, in_sel     - input word and its destination (SEL_A / SEL_B)
//   a_valid/a_ready     - port A handshake, a_data port A word
//   b_valid/b_ready     - port B handshake, b_data port B word
//   a_count, b_count    - words accepted into A / B since reset (wrapping)
// -----------------------------------------------------------------------------
module demux_stream
   import demux_stream_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = DEFAULT_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sel,
   output logic             a_valid,
   input  logic             a_ready,
   output logic [WIDTH-1:0] a_data,
   output logic             b_valid,
   input  logic             b_ready,
   output logic [WIDTH-1:0] b_data,
   output logic [CNT_W-1:0] a_count,
   output logic [CNT_W-1:0] b_count
);

   logic             in_ready_s;
   logic             a_load_s;
   logic             b_load_s;
   logic             a_full_s;
   logic             b_full_s;
   logic [WIDTH-1:0] a_data_s;
   logic [WIDTH-1:0] b_data_s;
   logic [CNT_W-1:0] a_count_r;
   logic [CNT_W-1:0] b_count_r;

   // Accept when the selected slot is empty or being drained this cycle;
   // in_valid only qualifies the load, never the ready.
   always_comb begin
      in_ready_s = 1'b0;
      a_load_s   = 1'b0;
      b_load_s   = 1'b0;
      if (rst) begin
         in_ready_s = 1'b0;
      end else if (in_sel == SEL_B) begin
         in_ready_s = (!b_full_s) || b_ready;
      end else begin
         in_ready_s = (!a_full_s) || a_ready;
      end
      a_load_s = in_valid && in_ready_s && (in_sel == SEL_A);
      b_load_s = in_valid && in_ready_s && (in_sel == SEL_B);
   end

   demux_slot #(
      .WIDTH (WIDTH)
   ) u_slot_a (
      .clk       (clk),
      .rst       (rst),
      .load      (a_load_s),
      .load_data (in_data),
      .out_ready (a_ready),
      .full      (a_full_s),
      .data      (a_data_s)
   );

   demux_slot #(
      .WIDTH (WIDTH)
   ) u_slot_b (
      .clk       (clk),
      .rst       (rst),
      .load      (b_load_s),
      .load_data (in_data),
      .out_ready (b_ready),
      .full      (b_full_s),
      .data      (b_data_s)
   );

   // Per-port accepted-word counters; natural binary wrap at 2^CNT_W.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_count_r <= {CNT_W{1'b0}};
         b_count_r <= {CNT_W{1'b0}};
      end else begin
         if (a_load_s) begin
            a_count_r <= a_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            a_count_r <= a_count_r;
         end
         if (b_load_s) begin
            b_count_r <= b_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            b_count_r <= b_count_r;
         end
      end
   end

   assign in_ready = in_ready_s;
   assign a_valid  = a_full_s;
   assign a_data   = a_data_s;
   assign b_valid  = b_full_s;
   assign b_data   = b_data_s;
   assign a_count  = a_count_r;
   assign b_count  = b_count_r;

endmodule : demux_stream

// File: tb/tb_demux_stream.sv
// -----------------------------------------------------------------------------
// tb_demux_stream
// Directed bench for demux_stream with default parameters (WIDTH=2, CNT_W=8).
// Inputs change 1 time unit after a rising edge; outputs are sampled there
// too, so registered values reflect the edge just taken and in_ready is
// sampled after its inputs settle.
// -----------------------------------------------------------------------------
module tb_demux_stream;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] in_data;
   logic       in_sel;
   logic       a_valid;
   logic       a_ready;
   logic [1:0] a_data;
   logic       b_valid;
   logic       b_ready;
   logic [1:0] b_data;
   logic [7:0] a_count;
   logic [7:0] b_count;

   int total;
   int bad;

   demux_stream dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_sel   (in_sel),
      .a_valid  (a_valid),
      .a_ready  (a_ready),
      .a_data   (a_data),
      .b_valid  (b_valid),
      .b_ready  (b_ready),
      .b_data   (b_data),
      .a_count  (a_count),
      .b_count  (b_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) else begin
         bad = bad + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      rst      = 1'b1;
      in_valid = 1'b1;
      in_data  = 2'b10;
      in_sel   = 1'b0;
      a_ready  = 1'b1;
      b_ready  = 1'b1;

      // Reset: nothing accepted even with valid input offered.
      step();
      settle();
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      step();
      chk("rst_a_valid", {31'd0, a_valid}, 32'd0);
      chk("rst_b_valid", {31'd0, b_valid}, 32'd0);
      chk("rst_a_data",  {30'd0, a_data},  32'd0);
      chk("rst_b_data",  {30'd0, b_data},  32'd0);
      chk("rst_a_count", {24'd0, a_count}, 32'd0);
      chk("rst_b_count", {24'd0, b_count}, 32'd0);

      // First word to A, 1-cycle latency.
      rst      = 1'b0;
      a_ready  = 1'b0;
      b_ready  = 1'b0;
      in_valid = 1'b1;
      in_sel   = 1'b0;
      in_data  = 2'b01;
      settle();
      chk("first_in_ready", {31'd0, in_ready}, 32'd1);
      step();
      chk("first_a_valid", {31'd0, a_valid}, 32'd1);
      chk("first_a_data",  {30'd0, a_data},  32'd1);
      chk("first_b_valid", {31'd0, b_valid}, 32'd0);
      chk("first_a_count", {24'd0, a_count}, 32'd1);

      // A full and stalled: input to A is blocked, A holds.
      in_data = 2'b10;
      settle();
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      step();
      chk("stall_a_valid", {31'd0, a_valid}, 32'd1);
      chk("stall_a_data",  {30'd0, a_data},  32'd1);
      chk("stall_a_count", {24'd0, a_count}, 32'd1);

      // A stalled, word to B still goes through; A untouched.
      in_sel  = 1'b1;
      in_data = 2'b11;
      settle();
      chk("toB_in_ready", {31'd0, in_ready}, 32'd1);
      step();
      chk("toB_b_valid", {31'd0, b_valid}, 32'd1);
      chk("toB_b_data",  {30'd0, b_data},  32'd3);
      chk("toB_a_data",  {30'd0, a_data},  32'd1);
      chk("toB_b_count", {24'd0, b_count}, 32'd1);
      chk("toB_a_count", {24'd0, a_count}, 32'd1);

      // Back-to-back into draining A: no bubbles, B holds its word.
      a_ready = 1'b1;
      in_sel  = 1'b0;
      for (int k = 0; k < 4; k++) begin
         in_data = k[1:0];
         settle();
         chk($sformatf("burst_in_ready_%0d", k), {31'd0, in_ready}, 32'd1);
         step();
         chk($sformatf("burst_a_valid_%0d", k), {31'd0, a_valid}, 32'd1);
         chk($sformatf("burst_a_data_%0d", k),  {30'd0, a_data},  k);
      end
      chk("burst_a_count", {24'd0, a_count}, 32'd5);
      chk("burst_b_data",  {30'd0, b_data},  32'd3);
      chk("burst_b_valid", {31'd0, b_valid}, 32'd1);

      // Drain A with no input: A empties, data holds last value.
      in_valid = 1'b0;
      step();
      chk("drain_a_valid", {31'd0, a_valid}, 32'd0);
      chk("drain_a_data",  {30'd0, a_data},  32'd3);
      chk("drain_a_count", {24'd0, a_count}, 32'd5);

      // Drain B while loading A in the same cycle.
      a_ready  = 1'b0;
      b_ready  = 1'b1;
      in_valid = 1'b1;
      in_sel   = 1'b0;
      in_data  = 2'b10;
      step();
      chk("indep_a_valid", {31'd0, a_valid}, 32'd1);
      chk("indep_a_data",  {30'd0, a_data},  32'd2);
      chk("indep_b_valid", {31'd0, b_valid}, 32'd0);
      chk("indep_a_count", {24'd0, a_count}, 32'd6);

      // 256 transfers to B: b_count goes 1 -> 0 after 255, back to 1 after 256.
      in_sel = 1'b1;
      for (int i = 0; i < 256; i++) begin
         in_data = i[1:0];
         step();
         if (i == 254) begin
            chk("wrap_b_count_zero", {24'd0, b_count}, 32'd0);
         end
      end
      chk("wrap_b_count", {24'd0, b_count}, 32'd1);
      chk("wrap_b_data",  {30'd0, b_data},  32'd3);
      chk("wrap_a_count", {24'd0, a_count}, 32'd6);
      chk("wrap_a_data",  {30'd0, a_data},  32'd2);

      // Both ports full, then reset mid-operation.
      b_ready  = 1'b0;
      in_valid = 1'b0;
      step();
      chk("pre_rst_a_valid", {31'd0, a_valid}, 32'd1);
      chk("pre_rst_b_valid", {31'd0, b_valid}, 32'd1);
      rst      = 1'b1;
      in_valid = 1'b1;
      in_sel   = 1'b0;
      a_ready  = 1'b1;
      settle();
      chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
      step();
      chk("mid_rst_a_valid", {31'd0, a_valid}, 32'd0);
      chk("mid_rst_b_valid", {31'd0, b_valid}, 32'd0);
      chk("mid_rst_a_count", {24'd0, a_count}, 32'd0);
      chk("mid_rst_b_count", {24'd0, b_count}, 32'd0);
      chk("mid_rst_a_data",  {30'd0, a_data},  32'd0);
      chk("mid_rst_in_ready2", {31'd0, in_ready}, 32'd0);

      // Resume after reset.
      rst     = 1'b0;
      a_ready = 1'b0;
      in_sel  = 1'b1;
      in_data = 2'b10;
      settle();
      chk("resume_in_ready", {31'd0, in_ready}, 32'd1);
      step();
      chk("resume_b_valid", {31'd0, b_valid}, 32'd1);
      chk("resume_b_data",  {30'd0, b_data},  32'd2);
      chk("resume_b_count", {24'd0, b_count}, 32'd1);
      chk("resume_a_valid", {31'd0, a_valid}, 32'd0);
      chk("resume_a_count", {24'd0, a_count}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_demux_stream
